// File: rtl/ex_sequencer.sv
// Execute-stage sequencer: accepts one decoded instruction, issues the register read, runs the ALU, and writes the result back.
// Latency: accept edge to WB_we is 2 + N cycles (N >= 1 EXEC cycles); minimum issue interval 4 cycles.
// Backpressure: DCR_ready is high only in IDLE (and never during reset); the decoder holds its fields until they are accepted.
module ex_sequencer #(
  parameter int ALU_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DCR_valid,
  output logic             DCR_ready,
  input  logic [4:0]       DCR_rs1_addr,
  input  logic [4:0]       DCR_rs2_addr,
  input  logic [4:0]       DCR_rd_addr,
  input  logic             DCR_imm_sel,
  input  logic [11:0]      DCR_imm_val,
  input  logic [3:0]       DCR_alu_op,
  input  logic             DCR_rd_we,
  output logic             RAW_rd_en,
  output logic [4:0]       RAW_rs1_addr,
  output logic [4:0]       RAW_rs2_addr,
  output logic             SEQ_imm_sel,
  output logic [11:0]      SEQ_imm_val,
  output logic [3:0]       SEQ_alu_op,
  output logic             SEQ_alu_en,
  input  logic             ALU_done,
  input  logic [31:0]      ALU_result,
  output logic             WB_we,
  output logic [4:0]       WB_addr,
  output logic [31:0]      WB_data,
  input  logic             SEQ_err_clr,
  output logic             SEQ_err,
  output logic             SEQ_busy,
  output logic [CNT_W-1:0] SEQ_retire_cnt
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  // Timeout threshold fits in the 8-bit wait counter (legal range 1..255).
  localparam logic [7:0] TIMEOUT_CNT = 8'(ALU_TIMEOUT);

  state_t            state, state_nxt;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic              imm_sel_q;
  logic [11:0]       imm_val_q;
  logic [3:0]        alu_op_q;
  logic              rd_we_q;
  logic [31:0]       result_q;
  logic [7:0]        wait_cnt;
  logic              err_q;
  logic [CNT_W-1:0]  retire_q;
  logic              accept;
  logic              timeout;

  // Ready is the only Mealy-ish output: gated by rst so it reads 0 while reset is held.
  assign DCR_ready = (state == IDLE) && !rst;
  assign accept    = DCR_valid && DCR_ready;
  assign timeout   = (state == EXEC) && !ALU_done && (wait_cnt == TIMEOUT_CNT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and strobe decode; ALU_done has priority over the timeout.
  always_comb begin
    state_nxt  = state;
    RAW_rd_en  = 1'b0;
    SEQ_alu_en = 1'b0;
    WB_we      = 1'b0;
    SEQ_busy   = 1'b1;
    case (state)
      IDLE: begin
        SEQ_busy = 1'b0;
        if (accept) state_nxt = READ;
      end
      READ: begin
        RAW_rd_en = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        SEQ_alu_en = 1'b1;
        if (ALU_done)     state_nxt = WB;
        else if (timeout) state_nxt = IDLE;
      end
      WB: begin
        WB_we     = rd_we_q && (rd_q != 5'd0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the decoded instruction on acceptance; fields hold until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_sel_q <= 1'b0;
      imm_val_q <= '0;
      alu_op_q  <= '0;
      rd_we_q   <= 1'b0;
    end else if (accept) begin
      rs1_q     <= DCR_rs1_addr;
      rs2_q     <= DCR_rs2_addr;
      rd_q      <= DCR_rd_addr;
      imm_sel_q <= DCR_imm_sel;
      imm_val_q <= DCR_imm_val;
      alu_op_q  <= DCR_alu_op;
      rd_we_q   <= DCR_rd_we;
    end
  end

  // Capture the ALU result on the done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           result_q <= '0;
    else if (state == EXEC && ALU_done) result_q <= ALU_result;
  end

  // Wait counter: 1 on the first EXEC cycle, +1 for every EXEC cycle without done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         wait_cnt <= '0;
    else if (state == READ)                          wait_cnt <= 8'd1;
    else if (state == EXEC && !ALU_done && !timeout) wait_cnt <= wait_cnt + 8'd1;
  end

  // Sticky timeout flag; a simultaneous set beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              err_q <= 1'b0;
    else if (timeout)     err_q <= 1'b1;
    else if (SEQ_err_clr) err_q <= 1'b0;
  end

  // Retired-instruction counter: one per WB cycle, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              retire_q <= '0;
    else if (state == WB) retire_q <= retire_q + CNT_W'(1);
  end

  assign RAW_rs1_addr   = rs1_q;
  assign RAW_rs2_addr   = rs2_q;
  assign SEQ_imm_sel    = imm_sel_q;
  assign SEQ_imm_val    = imm_val_q;
  assign SEQ_alu_op     = alu_op_q;
  assign WB_addr        = rd_q;
  assign WB_data        = result_q;
  assign SEQ_err        = err_q;
  assign SEQ_retire_cnt = retire_q;

endmodule

// File: tb/tb_ex_sequencer.sv
// Bench for ex_sequencer: scenario tasks drive instructions, a write-back scoreboard checks WB address/data.
// Latency: outputs sampled on the falling edge; the cycle counter measures accept-to-WB distance.
// Backpressure: instructions are held on the DCR port until DCR_ready is seen.
module tb_ex_sequencer;

  localparam int TO = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          DCR_valid = 1'b0;
  logic          DCR_ready;
  logic [4:0]    DCR_rs1_addr = '0, DCR_rs2_addr = '0, DCR_rd_addr = '0;
  logic          DCR_imm_sel = 1'b0;
  logic [11:0]   DCR_imm_val = '0;
  logic [3:0]    DCR_alu_op = '0;
  logic          DCR_rd_we = 1'b0;
  logic          RAW_rd_en;
  logic [4:0]    RAW_rs1_addr, RAW_rs2_addr;
  logic          SEQ_imm_sel;
  logic [11:0]   SEQ_imm_val;
  logic [3:0]    SEQ_alu_op;
  logic          SEQ_alu_en;
  logic          ALU_done = 1'b0;
  logic [31:0]   ALU_result;
  logic          WB_we;
  logic [4:0]    WB_addr;
  logic [31:0]   WB_data;
  logic          SEQ_err_clr = 1'b0;
  logic          SEQ_err;
  logic          SEQ_busy;
  logic [CW-1:0] SEQ_retire_cnt;

  ex_sequencer #(.ALU_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .DCR_valid(DCR_valid), .DCR_ready(DCR_ready),
    .DCR_rs1_addr(DCR_rs1_addr), .DCR_rs2_addr(DCR_rs2_addr), .DCR_rd_addr(DCR_rd_addr),
    .DCR_imm_sel(DCR_imm_sel), .DCR_imm_val(DCR_imm_val), .DCR_alu_op(DCR_alu_op),
    .DCR_rd_we(DCR_rd_we),
    .RAW_rd_en(RAW_rd_en), .RAW_rs1_addr(RAW_rs1_addr), .RAW_rs2_addr(RAW_rs2_addr),
    .SEQ_imm_sel(SEQ_imm_sel), .SEQ_imm_val(SEQ_imm_val), .SEQ_alu_op(SEQ_alu_op),
    .SEQ_alu_en(SEQ_alu_en), .ALU_done(ALU_done), .ALU_result(ALU_result),
    .WB_we(WB_we), .WB_addr(WB_addr), .WB_data(WB_data),
    .SEQ_err_clr(SEQ_err_clr), .SEQ_err(SEQ_err), .SEQ_busy(SEQ_busy),
    .SEQ_retire_cnt(SEQ_retire_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stub: result depends on the operands the sequencer presents.
  logic [31:0] res_base = '0;
  assign ALU_result = res_base ^ {20'h0, SEQ_imm_val} ^ {28'h0, SEQ_alu_op};

  typedef struct { logic [4:0] addr; logic [31:0] data; } wb_exp_t;
  wb_exp_t sb_q[$];
  wb_exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;
  logic [CW-1:0] cnt0;

  // Scoreboard consumer: every write-back must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && WB_we) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got addr=%0d data=%h, required no write", WB_addr, WB_data);
      end else begin
        mon_e = sb_q.pop_front();
        if ({WB_addr, WB_data} !== {mon_e.addr, mon_e.data}) begin
          errors++;
          $display("FAIL wb_data got addr=%0d data=%h, required addr=%0d data=%h",
                   WB_addr, WB_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  // Present an instruction at a falling edge, wait (bounded) for acceptance, return one cycle later.
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic isel, input logic [11:0] imm, input logic [3:0] op,
                       input logic we, input logic exp_wb);
    int k;
    DCR_rs1_addr = rs1; DCR_rs2_addr = rs2; DCR_rd_addr = rd;
    DCR_imm_sel = isel; DCR_imm_val = imm; DCR_alu_op = op; DCR_rd_we = we;
    DCR_valid = 1'b1;
    k = 0;
    while (!DCR_ready && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (DCR_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got %b required 1", DCR_ready);
    end
    acc_cyc = cyc;
    if (exp_wb && we && rd != 5'd0)
      sb_q.push_back('{rd, res_base ^ {20'h0, imm} ^ {28'h0, op}});
    @(negedge clk);
    DCR_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({DCR_ready, SEQ_busy, RAW_rd_en, SEQ_alu_en, WB_we, SEQ_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 000000",
               {DCR_ready, SEQ_busy, RAW_rd_en, SEQ_alu_en, WB_we, SEQ_err});
    end
    checks++;
    if ({RAW_rs1_addr, RAW_rs2_addr, SEQ_imm_sel, SEQ_imm_val, SEQ_alu_op, WB_addr, WB_data} !== 64'h0) begin
      errors++;
      $display("FAIL reset_fields got %h required 0",
               {RAW_rs1_addr, RAW_rs2_addr, SEQ_imm_sel, SEQ_imm_val, SEQ_alu_op, WB_addr, WB_data});
    end
    checks++;
    if (SEQ_retire_cnt !== '0) begin
      errors++; $display("FAIL reset_retire got %0d required 0", SEQ_retire_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (DCR_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b required 1", DCR_ready);
    end
  endtask

  task automatic test_rtype();
    ALU_done = 1'b1; res_base = 32'h7;
    issue(5'd1, 5'd2, 5'd3, 1'b0, 12'h0, 4'h0, 1'b1, 1'b1);
    checks++;
    if ({RAW_rd_en, RAW_rs1_addr, RAW_rs2_addr, DCR_ready, SEQ_alu_en} !== {1'b1, 5'd1, 5'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rtype_read got en=%b rs1=%0d rs2=%0d rdy=%b alu_en=%b required 1 1 2 0 0",
               RAW_rd_en, RAW_rs1_addr, RAW_rs2_addr, DCR_ready, SEQ_alu_en);
    end
    @(negedge clk);
    checks++;
    if ({SEQ_alu_en, SEQ_imm_sel, RAW_rd_en} !== 3'b100) begin
      errors++;
      $display("FAIL rtype_exec got %b required 100", {SEQ_alu_en, SEQ_imm_sel, RAW_rd_en});
    end
    @(negedge clk);
    checks++;
    if (WB_we !== 1'b1 || cyc - acc_cyc != 3) begin
      errors++;
      $display("FAIL rtype_wb_latency got we=%b cycles=%0d required we=1 cycles=3", WB_we, cyc - acc_cyc);
    end
    @(negedge clk);
    checks++;
    if ({SEQ_retire_cnt, WB_we, WB_addr, WB_data, DCR_ready} !== {32'd1, 1'b0, 5'd3, 32'd7, 1'b1}) begin
      errors++;
      $display("FAIL rtype_after got cnt=%0d we=%b addr=%0d data=%h rdy=%b required 1 0 3 7 1",
               SEQ_retire_cnt, WB_we, WB_addr, WB_data, DCR_ready);
    end
  endtask

  task automatic test_itype();
    ALU_done = 1'b0; res_base = 32'h0000_1000;
    issue(5'd4, 5'd5, 5'd6, 1'b1, 12'hFFF, 4'h3, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) ALU_done = 1'b1;
      checks++;
      if ({SEQ_alu_en, SEQ_imm_sel, SEQ_imm_val, SEQ_alu_op, DCR_ready} !== {1'b1, 1'b1, 12'hFFF, 4'h3, 1'b0}) begin
        errors++;
        $display("FAIL itype_exec_hold cycle %0d got en=%b sel=%b imm=%h op=%h rdy=%b required 1 1 fff 3 0",
                 i, SEQ_alu_en, SEQ_imm_sel, SEQ_imm_val, SEQ_alu_op, DCR_ready);
      end
    end
    @(negedge clk);
    ALU_done = 1'b0;
    checks++;
    if (WB_we !== 1'b1 || cyc - acc_cyc != 6) begin
      errors++;
      $display("FAIL itype_wb_latency got we=%b cycles=%0d required we=1 cycles=6", WB_we, cyc - acc_cyc);
    end
    @(negedge clk);
    checks++;
    if (SEQ_retire_cnt !== 32'd2 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL itype_retire got cnt=%0d pending=%0d required 2 0", SEQ_retire_cnt, sb_q.size());
    end
  endtask

  task automatic test_no_write();
    ALU_done = 1'b1; res_base = 32'h55;
    for (int t = 0; t < 2; t++) begin
      cnt0 = SEQ_retire_cnt;
      if (t == 0) issue(5'd7, 5'd8, 5'd0, 1'b0, 12'h0, 4'h1, 1'b1, 1'b1);
      else        issue(5'd9, 5'd10, 5'd9, 1'b0, 12'h0, 4'h2, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (WB_we !== 1'b0) begin
          errors++; $display("FAIL nowrite_we case %0d cycle %0d got %b required 0", t, c, WB_we);
        end
        @(negedge clk);
      end
      checks++;
      if (SEQ_retire_cnt !== cnt0 + 1 || SEQ_busy !== 1'b0) begin
        errors++;
        $display("FAIL nowrite_retire case %0d got cnt=%0d busy=%b required %0d 0",
                 t, SEQ_retire_cnt, SEQ_busy, cnt0 + 1);
      end
    end
  endtask

  task automatic test_timeout();
    ALU_done = 1'b0;
    cnt0 = SEQ_retire_cnt;
    issue(5'd1, 5'd2, 5'd3, 1'b0, 12'h0, 4'h5, 1'b1, 1'b0);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      checks++;
      if ({SEQ_alu_en, SEQ_err} !== 2'b10) begin
        errors++; $display("FAIL timeout_wait cycle %0d got en/err=%b required 10", i, {SEQ_alu_en, SEQ_err});
      end
    end
    @(negedge clk);
    checks++;
    if ({SEQ_err, SEQ_busy, DCR_ready, WB_we} !== 4'b1010 || SEQ_retire_cnt !== cnt0) begin
      errors++;
      $display("FAIL timeout_abort got err/busy/rdy/we=%b cnt=%0d required 1010 cnt=%0d",
               {SEQ_err, SEQ_busy, DCR_ready, WB_we}, SEQ_retire_cnt, cnt0);
    end
    issue(5'd1, 5'd2, 5'd3, 1'b0, 12'h0, 4'h5, 1'b1, 1'b0);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      if (i == TO) SEQ_err_clr = 1'b1;
    end
    @(negedge clk);
    SEQ_err_clr = 1'b0;
    checks++;
    if (SEQ_err !== 1'b1) begin
      errors++; $display("FAIL timeout_set_wins got %b required 1", SEQ_err);
    end
    SEQ_err_clr = 1'b1;
    @(negedge clk);
    SEQ_err_clr = 1'b0;
    checks++;
    if (SEQ_err !== 1'b0 || SEQ_retire_cnt !== cnt0) begin
      errors++;
      $display("FAIL timeout_clear got err=%b cnt=%0d required 0 %0d", SEQ_err, SEQ_retire_cnt, cnt0);
    end
  endtask

  task automatic test_reset_mid();
    ALU_done = 1'b0;
    issue(5'd11, 5'd12, 5'd13, 1'b1, 12'h5A5, 4'h9, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (SEQ_alu_en !== 1'b1) begin
      errors++; $display("FAIL resetmid_in_exec got %b required 1", SEQ_alu_en);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({DCR_ready, SEQ_busy, RAW_rd_en, SEQ_alu_en, WB_we, SEQ_err, SEQ_imm_sel, SEQ_imm_val,
         SEQ_alu_op, WB_addr, WB_data, RAW_rs1_addr, RAW_rs2_addr, SEQ_retire_cnt} !== '0) begin
      errors++;
      $display("FAIL resetmid_outputs got busy=%b en=%b imm=%h op=%h rs1=%0d cnt=%0d required all 0",
               SEQ_busy, SEQ_alu_en, SEQ_imm_val, SEQ_alu_op, RAW_rs1_addr, SEQ_retire_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (DCR_ready !== 1'b1) begin
      errors++; $display("FAIL resetmid_ready got %b required 1", DCR_ready);
    end
    @(negedge clk);
    ALU_done = 1'b1; res_base = 32'hCAFE_0000;
    issue(5'd14, 5'd15, 5'd16, 1'b0, 12'h0, 4'h4, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (WB_we !== 1'b1 || cyc - acc_cyc != 3) begin
      errors++;
      $display("FAIL resetmid_wb got we=%b cycles=%0d required 1 3", WB_we, cyc - acc_cyc);
    end
    @(negedge clk);
    checks++;
    if (SEQ_retire_cnt !== 32'd1) begin
      errors++; $display("FAIL resetmid_retire got %0d required 1", SEQ_retire_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int n;
    ALU_done = 1'b1; res_base = 32'h0000_0100;
    cnt0 = SEQ_retire_cnt;
    n = 0;
    DCR_rs1_addr = 5'd0; DCR_rs2_addr = 5'd1; DCR_rd_addr = 5'd20;
    DCR_imm_sel = 1'b0; DCR_imm_val = 12'h010; DCR_alu_op = 4'h0; DCR_rd_we = 1'b1;
    DCR_valid = 1'b1;
    for (int k = 0; k < 40 && n < 3; k++) begin
      if (DCR_ready) begin
        acc[n] = cyc;
        sb_q.push_back('{DCR_rd_addr, res_base ^ {20'h0, DCR_imm_val} ^ {28'h0, DCR_alu_op}});
        n++;
        @(negedge clk);
        if (n < 3) begin
          DCR_rs1_addr = 5'(n); DCR_rs2_addr = 5'(n + 1); DCR_rd_addr = 5'(20 + n);
          DCR_imm_sel = n[0]; DCR_imm_val = 12'(16 * (n + 1)); DCR_alu_op = 4'(n);
        end else begin
          DCR_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    DCR_valid = 1'b0;
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL b2b_accepted got %0d required 3", n);
    end else begin
      checks++;
      if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
        errors++;
        $display("FAIL b2b_interval got %0d %0d required 4 4", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (SEQ_retire_cnt !== cnt0 + 3 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_retire got cnt=%0d pending=%0d required %0d 0", SEQ_retire_cnt, sb_q.size(), cnt0 + 3);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_no_write();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_sequencer.md
# ex_sequencer

Execute-stage sequencer for the CMPE 140 RISC-V core. It accepts one decoded instruction at a time from the decoder over a valid/ready handshake and issues the register-file read. It then drives the operand-mux select, the 12-bit immediate and the ALU opcode, waits for the ALU to finish, and issues the register write-back. It sits between the decoder and the register-file/operand-mux/ALU datapath, and it is the only block that drives the ALU operand-mux select.

## Interface
Parameters:
- ALU_TIMEOUT, 16: maximum number of consecutive EXEC cycles without ALU_done before the instruction aborts. Legal range 1..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- DCR_valid  in  1  decoder has an instruction.
- DCR_ready  out  1  sequencer accepts an instruction this cycle.
- DCR_rs1_addr, DCR_rs2_addr, DCR_rd_addr  in  5 each  register indices.
- DCR_imm_sel  in  1  1 = ALU operand 2 is the immediate, 0 = rs2.
- DCR_imm_val  in  12  raw immediate; the operand mux sign-extends it, the sequencer does not.
- DCR_alu_op  in  4  ALU opcode.
- DCR_rd_we  in  1  instruction writes rd.
- RAW_rd_en  out  1  register-file read strobe; read data is valid to the mux on the next cycle.
- RAW_rs1_addr, RAW_rs2_addr  out  5 each  read addresses.
- SEQ_imm_sel  out  1  to operand-mux select.
- SEQ_imm_val  out  12  to operand-mux immediate input.
- SEQ_alu_op  out  4  to ALU.
- SEQ_alu_en  out  1  ALU operands and opcode are valid.
- ALU_done  in  1  ALU result is valid this cycle.
- ALU_result  in  32  ALU result.
- WB_we  out  1  register write enable.
- WB_addr  out  5  write address.
- WB_data  out  32  write data.
- SEQ_err_clr  in  1  clears SEQ_err.
- SEQ_err  out  1  sticky ALU-timeout flag.
- SEQ_busy  out  1  state is not IDLE.
- SEQ_retire_cnt  out  CNT_W  count of completed instructions.

## Operation
- FSM states: IDLE, READ, EXEC, WB. All outputs except DCR_ready are Moore outputs, decoded from the state register and the latched instruction fields.
- IDLE
  - DCR_ready = 1.
  - On DCR_valid & DCR_ready: latch all DCR_* fields, then go to READ.
  - DCR_valid without ready is ignored; the decoder holds its fields until accepted.
- READ (exactly 1 cycle)
  - RAW_rd_en = 1; RAW_rs1_addr and RAW_rs2_addr = latched rs1/rs2.
  - Go to EXEC.
- EXEC
  - SEQ_alu_en = 1; SEQ_imm_sel, SEQ_imm_val and SEQ_alu_op = latched values, held stable for the whole state.
  - Wait counter loads 1 on entry and increments each cycle ALU_done = 0.
  - ALU_done = 1: capture ALU_result into the result register, go to WB. Done in the first EXEC cycle is legal (combinational ALU).
  - Counter reaches ALU_TIMEOUT with ALU_done = 0 on that cycle: set SEQ_err, go to IDLE. No write-back, no retire.
- WB (exactly 1 cycle)
  - WB_we = latched rd_we & (rd != 0); WB_addr = latched rd; WB_data = captured result.
  - SEQ_retire_cnt increments on every WB cycle, including rd = 0 and rd_we = 0.
  - Go to IDLE.
- SEQ_imm_sel, SEQ_imm_val, SEQ_alu_op, RAW_*_addr and WB_addr/WB_data hold their last latched values outside their active states. Only the enables/strobes (RAW_rd_en, SEQ_alu_en, WB_we) return to 0.
- SEQ_err: set by timeout, cleared by SEQ_err_clr. Set and clear in the same cycle: set wins.
- SEQ_retire_cnt wraps from 2^CNT_W-1 to 0.

## Timing
- Reset: state = IDLE. All latched fields, the result register, the wait counter, SEQ_retire_cnt and SEQ_err are 0. Every output is 0, including DCR_ready, which is 0 while rst is high and 1 from the first cycle after release.
- Reset mid-operation: immediate return to IDLE. Any pending write-back is dropped (WB_we falls asynchronously) and the counter is not incremented.
- Latency:
  - Accept edge to WB_we = 2 + N cycles, where N ≥ 1 is the number of EXEC cycles.
  - Minimum issue interval is 4 cycles (IDLE, READ, EXEC, WB).
  - DCR_ready is low from the cycle after acceptance until the state returns to IDLE.
- SEQ_busy = 1 in READ, EXEC and WB.

## Test plan
- Reset then one R-type instruction: rs1=1, rs2=2, rd=3, imm_sel=0, op=0, ALU_done tied high, ALU_result=0x0000_0007.
  - Expect RAW_rd_en high for 1 cycle, then SEQ_alu_en high for 1 cycle with SEQ_imm_sel=0.
  - Expect WB_we=1, WB_addr=3, WB_data=7 exactly 3 cycles after acceptance, and SEQ_retire_cnt=1.
- I-type with imm_val=0xFFF and imm_sel=1; ALU_done delayed 3 cycles.
  - Expect SEQ_imm_sel=1 and SEQ_imm_val=0xFFF held stable for 4 EXEC cycles, DCR_ready=0 throughout, and WB 6 cycles after acceptance.
- rd=0 with rd_we=1 -> WB_we stays 0 and SEQ_retire_cnt still increments.
- ALU_TIMEOUT=4 with ALU_done never asserted.
  - Expect SEQ_err=1 after 4 EXEC cycles, return to IDLE, no WB_we, counter unchanged.
  - Then SEQ_err_clr together with a second timeout event -> SEQ_err remains 1.
- Assert rst during EXEC -> all outputs 0 immediately; after release DCR_ready=1 and a new instruction completes normally.
- Back-to-back DCR_valid held high for 3 instructions -> accepted exactly every 4 cycles with done immediate, and SEQ_retire_cnt=3.
